// File: rtl/counter_buffer_ctrl_if.sv
// Signal bundle between the sample-buffer sequencer, the counter core, the bus
// register bank and the dual-port sample SRAM.
interface counter_buffer_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18
);
    logic                  i_start;
    logic                  i_stop;
    logic                  i_continuous;
    logic                  i_sample_valid;
    logic [DATA_WIDTH-1:0] i_sample_data;
    logic                  o_sample_drop;
    logic [1:0]            o_state;
    logic [ADDR_WIDTH-1:0] o_wr_ptr;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_wrapped;
    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  o_rd_ack;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic [ADDR_WIDTH-1:0] o_sram_addr_a;
    logic                  o_sram_we_a;
    logic [DATA_WIDTH-1:0] o_sram_data_a;
    logic [ADDR_WIDTH-1:0] o_sram_addr_b;
    logic                  o_sram_we_b;
    logic [DATA_WIDTH-1:0] o_sram_data_b;
    logic [DATA_WIDTH-1:0] i_sram_data_b;

    modport slave (
        input  i_start, i_stop, i_continuous, i_sample_valid, i_sample_data,
        input  i_rd_req, i_rd_addr, i_sram_data_b,
        output o_sample_drop, o_state, o_wr_ptr, o_count, o_wrapped,
        output o_rd_ack, o_rd_data,
        output o_sram_addr_a, o_sram_we_a, o_sram_data_a,
        output o_sram_addr_b, o_sram_we_b, o_sram_data_b
    );

    modport master (
        output i_start, i_stop, i_continuous, i_sample_valid, i_sample_data,
        output i_rd_req, i_rd_addr, i_sram_data_b,
        input  o_sample_drop, o_state, o_wr_ptr, o_count, o_wrapped,
        input  o_rd_ack, o_rd_data,
        input  o_sram_addr_a, o_sram_we_a, o_sram_data_a,
        input  o_sram_addr_b, o_sram_we_b, o_sram_data_b
    );
endinterface

// File: rtl/counter_buffer_ctrl.sv
// Sample SRAM sequencer: zero-fill then linear/circular recording on port A,
// logical-to-physical bus reads on port B. DEPTH must equal 2**ADDR_WIDTH.
module counter_buffer_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4096
) (
    input logic i_clk,
    input logic i_rstn,
    counter_buffer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH:0]   FULL      = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_C     = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wrapped_q, wrapped_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  drop_q, drop_d;
    logic                  samp_we_q, samp_we_d;
    logic [ADDR_WIDTH-1:0] samp_addr_q, samp_addr_d;
    logic [DATA_WIDTH-1:0] samp_data_q, samp_data_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  accept;
    logic                  clearing;

    // A sample is lost whenever start or stop pre-empts recording in its cycle.
    assign accept   = (state_q == RUN) && bus.i_sample_valid && !bus.i_stop && !bus.i_start;
    assign clearing = (state_q == CLEAR);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        clr_addr_d  = clr_addr_q;
        samp_we_d   = 1'b0;
        samp_addr_d = '0;
        samp_data_d = '0;
        drop_d      = bus.i_sample_valid && !accept;

        if (bus.i_start) begin
            mode_d     = bus.i_continuous;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            clr_addr_d = '0;
            state_d    = CLEAR;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (bus.i_stop) begin
                        state_d = DONE;
                    end else if (clr_addr_q == LAST_ADDR) begin
                        state_d = RUN;
                    end else begin
                        clr_addr_d = clr_addr_q + ONE_A;
                    end
                end
                RUN: begin
                    if (bus.i_stop) begin
                        state_d = DONE;
                    end else if (accept) begin
                        samp_we_d   = 1'b1;
                        samp_addr_d = wr_ptr_q;
                        samp_data_d = bus.i_sample_data;
                        wr_ptr_d    = wr_ptr_q + ONE_A;
                        if (count_q == FULL) begin
                            wrapped_d = 1'b1;
                        end else begin
                            count_d = count_q + ONE_C;
                        end
                        if (!mode_q && (count_q == FULL - ONE_C)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read address is translated using the pointer as it stands in the request cycle.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (bus.i_rd_req) begin
            rd_addr_d = wrapped_q ? (wr_ptr_q + bus.i_rd_addr) : bus.i_rd_addr;
        end
        rd_pend_d = bus.i_rd_req;
        rd_ack_d  = rd_pend_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            clr_addr_q  <= '0;
            drop_q      <= 1'b0;
            samp_we_q   <= 1'b0;
            samp_addr_q <= '0;
            samp_data_q <= '0;
            rd_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            clr_addr_q  <= clr_addr_d;
            drop_q      <= drop_d;
            samp_we_q   <= samp_we_d;
            samp_addr_q <= samp_addr_d;
            samp_data_q <= samp_data_d;
            rd_addr_q   <= rd_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_ack_q    <= rd_ack_d;
        end
    end

    assign bus.o_state       = state_q;
    assign bus.o_wr_ptr      = wr_ptr_q;
    assign bus.o_count       = count_q;
    assign bus.o_wrapped     = wrapped_q;
    assign bus.o_sample_drop = drop_q;

    assign bus.o_sram_we_a   = clearing || samp_we_q;
    assign bus.o_sram_addr_a = clearing ? clr_addr_q : (samp_we_q ? samp_addr_q : '0);
    assign bus.o_sram_data_a = clearing ? '0 : samp_data_q;

    assign bus.o_sram_addr_b = rd_addr_q;
    assign bus.o_sram_we_b   = 1'b0;
    assign bus.o_sram_data_b = '0;

    assign bus.o_rd_ack      = rd_ack_q;
    assign bus.o_rd_data     = rd_ack_q ? bus.i_sram_data_b : '0;

endmodule

// File: tb/tb_counter_buffer_ctrl.sv
// Randomised scoreboard bench for counter_buffer_ctrl with a small SRAM and a
// cycle-level reference model of the recording and read-mapping rules.
module tb_counter_buffer_ctrl;

    localparam int AW = 4;
    localparam int DW = 18;
    localparam int D  = 16;

    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;

    always #5 i_clk = ~i_clk;

    counter_buffer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    counter_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    // Read-before-write dual-port SRAM with a registered port B.
    logic [DW-1:0] sram [D];
    logic [DW-1:0] sramQ = '0;

    assign bus.i_sram_data_b = sramQ;

    always @(posedge i_clk) begin
        sramQ <= sram[bus.o_sram_addr_b];
        if (bus.o_sram_we_a) sram[bus.o_sram_addr_a] <= bus.o_sram_data_a;
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rdExp_t;

    rdExp_t        expQ[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    int            mSt, mMode, mPtr, mCnt, mWrapped, mClr;
    logic [DW-1:0] mMem [D];
    bit            mDrop, mWe;
    int            mAddrA;
    logic [DW-1:0] mDataA;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pattern(int i);
        return DW'(32'h2A000 + i * 37);
    endfunction

    task automatic checkVal(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mSt = 0; mMode = 0; mPtr = 0; mCnt = 0; mWrapped = 0; mClr = 0;
        mDrop = 0; mWe = 0; mAddrA = 0; mDataA = '0;
        expQ.delete();
    endtask

    task automatic idleInputs();
        bus.i_start = 0; bus.i_stop = 0; bus.i_continuous = 0;
        bus.i_sample_valid = 0; bus.i_sample_data = '0;
        bus.i_rd_req = 0; bus.i_rd_addr = '0;
    endtask

    // Pops one expected read per ack; an ack that is late, early or missing counts as a miss.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            while (expQ.size() > 0 && expQ[0].due < cyc) begin
                checkVal("rd_ack_missing", 0, 1);
                void'(expQ.pop_front());
            end
            if (bus.o_rd_ack) begin
                if (expQ.size() == 0) begin
                    checkVal("rd_ack_spurious", 1, 0);
                end else begin
                    rdExp_t e;
                    e = expQ.pop_front();
                    checkVal("rd_ack_cycle", cyc, e.due);
                    checkVal("rd_data", bus.o_rd_data, e.data);
                end
            end
        end
    end

    task automatic checkOutput();
        checkVal("state", bus.o_state, mSt);
        checkVal("wr_ptr", bus.o_wr_ptr, mPtr);
        checkVal("count", bus.o_count, mCnt);
        checkVal("wrapped", bus.o_wrapped, mWrapped);
        checkVal("sample_drop", bus.o_sample_drop, mDrop);
        checkVal("we_a", bus.o_sram_we_a, mWe);
        if (mWe) begin
            checkVal("addr_a", bus.o_sram_addr_a, mAddrA);
            checkVal("data_a", bus.o_sram_data_a, mDataA);
        end
        checkVal("we_b", bus.o_sram_we_b, 0);
        checkVal("data_b", bus.o_sram_data_b, 0);
    endtask

    task automatic checkReset();
        checkVal("rst_state", bus.o_state, 0);
        checkVal("rst_wr_ptr", bus.o_wr_ptr, 0);
        checkVal("rst_count", bus.o_count, 0);
        checkVal("rst_wrapped", bus.o_wrapped, 0);
        checkVal("rst_drop", bus.o_sample_drop, 0);
        checkVal("rst_rd_ack", bus.o_rd_ack, 0);
        checkVal("rst_rd_data", bus.o_rd_data, 0);
        checkVal("rst_we_a", bus.o_sram_we_a, 0);
        checkVal("rst_addr_a", bus.o_sram_addr_a, 0);
        checkVal("rst_data_a", bus.o_sram_data_a, 0);
        checkVal("rst_addr_b", bus.o_sram_addr_b, 0);
    endtask

    // Drives one cycle, advances the reference model, then checks registered outputs.
    task automatic applyStimulus(bit sv, logic [DW-1:0] sd, bit rq, int ra, bit st, bit sp, bit cont);
        bit accepted;
        int oldPtr;
        bus.i_sample_valid = sv;
        bus.i_sample_data  = sd;
        bus.i_rd_req       = rq;
        bus.i_rd_addr      = AW'(ra);
        bus.i_start        = st;
        bus.i_stop         = sp;
        bus.i_continuous   = cont;

        if (rq) begin
            int phys;
            phys = mWrapped ? (mPtr + ra) % D : ra;
            expQ.push_back('{mMem[phys], cyc + 2});
        end
        accepted = (mSt == 2) && sv && !sp && !st;
        mDrop    = sv && !accepted;
        oldPtr   = mPtr;
        if (mSt == 1) mMem[mClr] = '0;

        if (st) begin
            mMode = cont; mPtr = 0; mCnt = 0; mWrapped = 0; mClr = 0; mSt = 1;
        end else if (mSt == 1) begin
            mClr++;
            if (sp) mSt = 3;
            else if (mClr == D) mSt = 2;
        end else if (mSt == 2) begin
            if (sp) begin
                mSt = 3;
            end else if (accepted) begin
                mMem[mPtr] = sd;
                if (mCnt == D) mWrapped = 1;
                mPtr = (mPtr + 1) % D;
                if (mCnt < D) mCnt++;
                if (mMode == 0 && mCnt == D) mSt = 3;
            end
        end

        mWe = 0; mAddrA = 0; mDataA = '0;
        if (mSt == 1) begin
            mWe = 1; mAddrA = mClr;
        end else if (accepted) begin
            mWe = 1; mAddrA = oldPtr; mDataA = sd;
        end

        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic readAll();
        for (int i = 0; i < D; i++) applyStimulus(0, '0, 1, i, 0, 0, 0);
        idle(3);
    endtask

    task automatic startAndClear(bit cont);
        applyStimulus(0, '0, 0, 0, 1, 0, cont);
        idle(D);
    endtask

    initial begin
        logic [DW-1:0] r;
        idleInputs();
        for (int i = 0; i < D; i++) begin
            sram[i] = pattern(i);
            mMem[i] = pattern(i);
        end
        modelReset();

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkReset();
        i_rstn = 1'b1;

        $display("[TB] single-shot record");
        startAndClear(0);
        for (int v = 1; v <= D; v++) applyStimulus(1, DW'(v), 0, 0, 0, 0, 0);
        applyStimulus(1, DW'(17), 0, 0, 0, 0, 0);
        readAll();

        $display("[TB] continuous record with wrap");
        startAndClear(1);
        for (int v = 1; v <= 20; v++) applyStimulus(1, DW'(v), 0, 0, 0, 0, 0);
        checkVal("wrap_flag", bus.o_wrapped, 1);
        checkVal("wrap_ptr", bus.o_wr_ptr, 4);
        readAll();

        $display("[TB] start+stop in RUN, then stop during CLEAR");
        applyStimulus(0, '0, 0, 0, 1, 1, 0);
        checkVal("restart_count", bus.o_count, 0);
        idle(4);
        applyStimulus(0, '0, 0, 0, 0, 1, 0);
        readAll();
        applyStimulus(0, '0, 0, 0, 0, 1, 0);

        $display("[TB] collisions and random traffic");
        startAndClear(1);
        applyStimulus(1, DW'('h111), 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(i[0], DW'('h200 + i), 1, (i + 1) % D, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            r = DW'($urandom);
            applyStimulus(bit'($urandom_range(0, 1)), r, $urandom_range(0, 3) != 0,
                          $urandom_range(0, D - 1), 0, 0, 0);
        end
        applyStimulus(1, DW'('h3AB), 0, 0, 0, 1, 0);
        idle(3);

        $display("[TB] reset during RUN");
        startAndClear(0);
        for (int v = 0; v < 5; v++) applyStimulus(1, DW'('h50 + v), 0, 0, 0, 0, 0);
        idleInputs();
        #1 i_rstn = 1'b0;
        #1 checkReset();
        modelReset();
        @(negedge i_clk);
        i_rstn = 1'b1;
        startAndClear(0);
        applyStimulus(1, DW'('h77), 1, 0, 0, 0, 0);
        idle(3);

        checkVal("rd_queue_empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_buffer_ctrl.md
# counter_buffer_ctrl

Sequencer and arbiter for the counter module's dual-port sample SRAM. Port A carries all writes: a zero-fill sweep on start, then incoming count samples as a linear or circular record. Port B carries system-bus reads, translated from logical index (0 = oldest sample) to physical address. The block sits between the counter core, the SRAM instance and the bus register bank.

## Interface
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 18, sample/SRAM word width
- DEPTH, 4096, SRAM entries; must equal 2**ADDR_WIDTH
- i_clk  in  1  clock, all logic rising-edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  pulse: begin zero-fill, then record
- i_stop  in  1  pulse: end recording
- i_continuous  in  1  1 = circular record, 0 = single-shot; sampled on i_start
- i_sample_valid, i_sample_data  in  1, DATA_WIDTH  count sample from counter core
- o_sample_drop  out  1  pulse: a valid sample was not stored
- o_state  out  2  IDLE=0, CLEAR=1, RUN=2, DONE=3
- o_wr_ptr  out  ADDR_WIDTH  next physical write address
- o_count  out  ADDR_WIDTH+1  stored samples, saturates at DEPTH
- o_wrapped  out  1  circular record has overwritten data
- i_rd_req, i_rd_addr  in  1, ADDR_WIDTH  bus read, logical index
- o_rd_ack, o_rd_data  out  1, DATA_WIDTH  read response
- o_sram_addr_a, o_sram_we_a, o_sram_data_a  out  SRAM port A
- o_sram_addr_b, o_sram_we_b, o_sram_data_b  out  SRAM port B; we_b and data_b are tied to 0
- i_sram_data_b  in  DATA_WIDTH  SRAM port B read data, registered, 1-cycle latency

## Operation
- Reset: state IDLE. o_wr_ptr, o_count, o_wrapped, o_sample_drop, o_rd_ack and o_rd_data are 0. All SRAM outputs are 0. Mode register is 0.
- Asserting reset mid-operation aborts immediately. SRAM contents are left as-is.
- i_start in any state:
  - latches the mode,
  - clears wr_ptr, count and wrapped,
  - sets the clear address to 0,
  - enters CLEAR.
- If i_start and i_stop arrive in the same cycle, start wins.
- CLEAR: writes zero via port A to addresses 0..DEPTH-1, one per cycle, then enters RUN. This takes exactly DEPTH cycles.
- RUN accepts a sample on every cycle where i_sample_valid=1 and the registered state is RUN.
- For each accepted sample:
  - port A writes the sample to wr_ptr,
  - wr_ptr increments mod DEPTH,
  - count increments, saturating at DEPTH.
- Single-shot, count reaching DEPTH: enters DONE on the same edge as the DEPTH-th write.
- Continuous: wr_ptr wraps. o_wrapped sets on the first accepted sample with count==DEPTH, i.e. the first overwrite. Count stays at DEPTH.
- i_stop in CLEAR or RUN: enter DONE. A sample in the same cycle is dropped. A stop during CLEAR leaves memory partially cleared.
- i_stop in IDLE or DONE has no effect.
- o_sample_drop pulses one cycle, registered, for any i_sample_valid while state is not RUN, or while stop is being applied.
- Read mapping:
  - physical address = (wr_ptr + i_rd_addr) mod DEPTH when wrapped, otherwise i_rd_addr.
  - wr_ptr is sampled in the request cycle.
- Reads are accepted every cycle in all states, with no backpressure.
- Indices >= count return the raw SRAM content (zeros after CLEAR). No error is flagged.

## Timing
- Sample valid in cycle N: in cycle N+1, o_sram_we_a=1, addr_a=old wr_ptr, data_a=sample. o_wr_ptr and o_count are updated in N+1.
- CLEAR write k (0-based) is presented in cycle S+1+k, where S is the i_start cycle. The first RUN cycle is S+1+DEPTH.
- Read request in cycle N: o_sram_addr_b is registered and valid in N+1. SRAM data arrives in N+2. o_rd_ack=1 in N+2, with o_rd_data = i_sram_data_b, combinational pass-through.
- Back-to-back requests produce back-to-back acks in order.
- A read hitting the address written by port A in the same SRAM cycle returns the old data, because the SRAM is read-before-write.
- o_state changes on the edge following the triggering input.

## Test plan
- Reset with rstn low, then release; pulse start with DEPTH=16 (ADDR_WIDTH=4) -> state goes 1 for 16 cycles, we_a=1, data_a=0, addresses 0..15; then state=2.
- Single-shot, 16 samples of values 1..16 -> state=3 right after the 16th write; count=16; a 17th sample -> o_sample_drop pulse; reads of indices 0..15 return 1..16 with ack 2 cycles after each request.
- Continuous, 20 samples of values 1..20 -> wrapped=1, wr_ptr=4, count=16; logical reads 0..15 return 5..20.
- Start and stop in the same cycle during RUN -> re-enters CLEAR, count=0; stop during CLEAR at cycle 5 -> DONE, only addresses 0..4 zeroed.
- 8 back-to-back read requests with interleaved sample writes -> 8 consecutive acks in order; a same-address collision returns pre-write data.
- Reset asserted mid-RUN -> all outputs 0 and state IDLE asynchronously; a following start behaves as in scenario 1.
